// File: rtl/param_stack_pkg.sv
// Shared definitions for the parameterised hardware stack: command
// encodings and the control FSM state type.
package stack_pkg;

  // Command encodings carried on the op field; 3'b110 and 3'b111 act as NOP.
  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_PUSH  = 3'b001,
    OP_POP   = 3'b010,
    OP_SWAP  = 3'b011,
    OP_PEEK  = 3'b100,
    OP_CLEAR = 3'b101
  } op_t;

  // Control FSM: IDLE accepts commands, CLEAR zeroes the storage.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/param_stack_if.sv
// Command/result bundle for param_stack.
//
// Handshake: a command is accepted on a rising clock edge where both
// op_valid and op_ready are high; op, write_data and offset are sampled on
// that edge only. op_ready is high whenever the stack is idle and low for the
// whole clear sweep. Read results appear on stack together with a one-cycle
// rd_valid pulse in the cycle after the accepting edge.
interface param_stack_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
);
  localparam int AW = $clog2(DEPTH);

  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op;
  logic [DATA_W-1:0] write_data;
  logic [AW-1:0]     offset;
  logic [DATA_W-1:0] stack;
  logic              rd_valid;
  logic [AW:0]       esp;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  modport master (
    output op_valid, op, write_data, offset,
    input  op_ready, stack, rd_valid, esp, empty, full, overflow, underflow
  );

  modport slave (
    input  op_valid, op, write_data, offset,
    output op_ready, stack, rd_valid, esp, empty, full, overflow, underflow
  );
endinterface

// File: rtl/param_stack_ram.sv
// Storage for param_stack: DEPTH x DATA_W, one write port, one read port
// with a registered, enable-gated read. The array itself has no reset; only
// the read register is reset/zeroed so the visible result starts at zero.
module stack_ram #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [AW-1:0]     ra,
  input  logic              rd_clr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; no reset so the array maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (we) mem[wa] <= wd;
  end

  // Read register: old data on a same-address write (read-before-write),
  // holds when not enabled, zeroed on reset or an explicit clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      q <= '0;
    else if (rd_clr) q <= '0;
    else if (re)     q <= mem[ra];
  end

endmodule

// File: rtl/param_stack.sv
// Downward-growing hardware stack with PUSH/POP/SWAP/PEEK/CLEAR commands,
// sticky overflow/underflow flags and a clear sweep after reset or CLEAR.
module param_stack
  import stack_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  param_stack_if.slave  bus,
  output state_t        dbg_state,
  output logic [AW-1:0] dbg_clr_idx
);

  localparam logic [AW:0]   ESP_EMPTY = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);

  state_t            state;
  state_t            state_nx;
  logic              op_ready;
  logic              clr_we;
  logic [AW-1:0]     clr_idx;
  logic [AW:0]       esp;
  logic              rd_valid;
  logic              ovf;
  logic              udf;
  logic [DATA_W-1:0] ram_q;

  logic              accept;
  logic              empty;
  logic              full;
  logic [AW+1:0]     peek_sum;
  logic              peek_ok;
  logic [AW:0]       esp_m1;
  logic              do_push;
  logic              do_pop;
  logic              do_swap;
  logic              do_peek;
  logic              push_ovf;
  logic              read_udf;
  logic              start_clear;

  logic              ram_we;
  logic [AW-1:0]     ram_wa;
  logic [DATA_W-1:0] ram_wd;
  logic              ram_re;
  logic [AW-1:0]     ram_ra;

  assign accept   = bus.op_valid && op_ready;
  assign empty    = (esp == ESP_EMPTY);
  assign full     = (esp == '0);
  assign peek_sum = {1'b0, esp} + {2'b00, bus.offset};
  assign peek_ok  = (peek_sum < (AW+2)'(DEPTH));
  assign esp_m1   = esp - (AW+1)'(1);

  // Command decode: legal operations and the error cases that only set a flag.
  always_comb begin
    do_push     = accept && (bus.op == OP_PUSH) && !full;
    push_ovf    = accept && (bus.op == OP_PUSH) && full;
    do_pop      = accept && (bus.op == OP_POP)  && !empty;
    do_swap     = accept && (bus.op == OP_SWAP) && !empty;
    do_peek     = accept && (bus.op == OP_PEEK) && peek_ok;
    read_udf    = accept && ((((bus.op == OP_POP) || (bus.op == OP_SWAP)) && empty) ||
                             ((bus.op == OP_PEEK) && !peek_ok));
    start_clear = accept && (bus.op == OP_CLEAR);
  end

  // FSM state register; reset lands directly in the clear sweep.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_CLEAR;
    else        state <= state_nx;
  end

  // FSM next state: sweep ends after the last entry has been written.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start_clear) state_nx = ST_CLEAR;
      ST_CLEAR: if (clr_idx == IDX_LAST) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs: commands are only taken while idle.
  always_comb begin
    op_ready = (state == ST_IDLE);
    clr_we   = (state == ST_CLEAR);
  end

  // RAM port steering; the clear sweep owns the write port while active.
  always_comb begin
    ram_we = clr_we || do_push || do_swap;
    ram_wa = esp[AW-1:0];
    ram_wd = bus.write_data;
    if (clr_we) begin
      ram_wa = clr_idx;
      ram_wd = '0;
    end else if (do_push) begin
      ram_wa = esp_m1[AW-1:0];
    end
    ram_re = do_pop || do_swap || do_peek;
    ram_ra = do_peek ? peek_sum[AW-1:0] : esp[AW-1:0];
  end

  // Stack pointer, sticky flags, result pulse and clear index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      esp      <= ESP_EMPTY;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      clr_idx  <= '0;
    end else begin
      rd_valid <= ram_re;
      if (start_clear) begin
        esp     <= ESP_EMPTY;
        ovf     <= 1'b0;
        udf     <= 1'b0;
        clr_idx <= '0;
      end else begin
        if (do_push)  esp <= esp_m1;
        if (do_pop)   esp <= esp + (AW+1)'(1);
        if (push_ovf) ovf <= 1'b1;
        if (read_udf) udf <= 1'b1;
        if (clr_we)   clr_idx <= clr_idx + AW'(1);
      end
    end
  end

  stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock  (clock),
    .reset  (reset),
    .we     (ram_we),
    .wa     (ram_wa),
    .wd     (ram_wd),
    .re     (ram_re),
    .ra     (ram_ra),
    .rd_clr (start_clear),
    .q      (ram_q)
  );

  assign bus.op_ready  = op_ready;
  assign bus.stack     = ram_q;
  assign bus.rd_valid  = rd_valid;
  assign bus.esp       = esp;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = ovf;
  assign bus.underflow = udf;
  assign dbg_state     = state;
  assign dbg_clr_idx   = clr_idx;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack: a DEPTH=4 instance carries the functional
// sequence, a default DEPTH=32 instance covers the post-reset clear length.
module tb_param_stack;
  import stack_pkg::*;

  logic   clock;
  logic   reset;
  int     checks;
  int     errors;
  state_t st4;
  state_t st32;
  logic [1:0] idx4;
  logic [4:0] idx32;
  logic [31:0] pv [4];

  param_stack_if #(.DATA_W(32), .DEPTH(4))  bus4 ();
  param_stack_if #(.DATA_W(32), .DEPTH(32)) bus32 ();

  param_stack #(.DATA_W(32), .DEPTH(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4), .dbg_state(st4), .dbg_clr_idx(idx4)
  );

  param_stack #(.DATA_W(32), .DEPTH(32)) dut32 (
    .clock(clock), .reset(reset), .bus(bus32), .dbg_state(st32), .dbg_clr_idx(idx32)
  );

  // clock / watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one command on the DEPTH=4 instance, waiting (bounded) for op_ready.
  task automatic issue(input logic [2:0] o, input logic [31:0] d, input logic [1:0] off);
    int n;
    n = 0;
    while (!bus4.op_ready && n < 64) begin
      tick();
      n++;
    end
    if (!bus4.op_ready) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout: observed=0 expected=1");
    end
    bus4.op_valid   = 1'b1;
    bus4.op         = o;
    bus4.write_data = d;
    bus4.offset     = off;
    @(posedge clock);
    #1;
    bus4.op_valid   = 1'b0;
    bus4.op         = OP_NOP;
    bus4.write_data = '0;
    bus4.offset     = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pv[0] = 32'h11; pv[1] = 32'h22; pv[2] = 32'h33; pv[3] = 32'h44;
    reset = 1'b0;
    bus4.op_valid = 1'b0;  bus4.op = OP_NOP;  bus4.write_data = '0;  bus4.offset = '0;
    bus32.op_valid = 1'b0; bus32.op = OP_NOP; bus32.write_data = '0; bus32.offset = '0;

    // reset state
    repeat (3) tick();
    chk("rst_esp",      bus4.esp, 4);
    chk("rst_stack",    bus4.stack, 0);
    chk("rst_rd_valid", bus4.rd_valid, 0);
    chk("rst_ovf",      bus4.overflow, 0);
    chk("rst_udf",      bus4.underflow, 0);
    chk("rst_ready",    bus4.op_ready, 0);
    chk("rst_state",    st4, ST_CLEAR);
    chk("rst_idx",      idx4, 0);
    chk("rst_empty",    bus4.empty, 1);
    chk("rst_full",     bus4.full, 0);

    // release reset: DEPTH=4 ready after 4 edges, DEPTH=32 after 32
    reset = 1'b1;
    chk("rel_ready4_0",  bus4.op_ready, 0);
    chk("rel_ready32_0", bus32.op_ready, 0);
    for (int i = 1; i <= 32; i++) begin
      tick();
      chk("rel_ready4",  bus4.op_ready, (i >= 4) ? 1 : 0);
      chk("rel_ready32", bus32.op_ready, (i >= 32) ? 1 : 0);
    end
    chk("rel_esp32",   bus32.esp, 32);
    chk("rel_empty32", bus32.empty, 1);
    chk("rel_esp4",    bus4.esp, 4);

    // POP on empty
    issue(OP_POP, 32'h0, 2'd0);
    chk("pope_udf",   bus4.underflow, 1);
    chk("pope_rdv",   bus4.rd_valid, 0);
    chk("pope_esp",   bus4.esp, 4);
    chk("pope_stack", bus4.stack, 0);
    tick();
    chk("pope_rdv2",  bus4.rd_valid, 0);

    // fill to full, then overflow, then pop
    for (int i = 0; i < 4; i++) begin
      issue(OP_PUSH, pv[i], 2'd0);
      chk("push_esp", bus4.esp, 3 - i);
    end
    chk("fill_full",  bus4.full, 1);
    chk("fill_empty", bus4.empty, 0);
    issue(OP_PUSH, 32'h55, 2'd0);
    chk("ovf_flag", bus4.overflow, 1);
    chk("ovf_esp",  bus4.esp, 0);
    issue(OP_POP, 32'h0, 2'd0);
    chk("pop_stack", bus4.stack, 32'h44);
    chk("pop_rdv",   bus4.rd_valid, 1);
    chk("pop_esp",   bus4.esp, 1);
    chk("pop_full",  bus4.full, 0);
    tick();
    chk("pop_rdv_end",  bus4.rd_valid, 0);
    chk("pop_hold",     bus4.stack, 32'h44);
    chk("sticky_udf",   bus4.underflow, 1);
    chk("sticky_ovf",   bus4.overflow, 1);

    // CLEAR with flags set
    issue(OP_CLEAR, 32'h0, 2'd0);
    chk("clr_ovf",   bus4.overflow, 0);
    chk("clr_udf",   bus4.underflow, 0);
    chk("clr_esp",   bus4.esp, 4);
    chk("clr_stack", bus4.stack, 0);
    chk("clr_state", st4, ST_CLEAR);
    for (int i = 0; i < 4; i++) begin
      chk("clr_ready_low", bus4.op_ready, 0);
      chk("clr_idx",       idx4, i);
      tick();
    end
    chk("clr_ready_high", bus4.op_ready, 1);
    for (int i = 0; i < 4; i++) chk("clr_mem_zero", dut4.u_ram.mem[i], 0);
    issue(OP_PUSH, 32'h99, 2'd0);
    chk("clr_push_esp", bus4.esp, 3);
    issue(OP_PEEK, 32'h0, 2'd1);
    chk("peek_oob_udf", bus4.underflow, 1);
    chk("peek_oob_rdv", bus4.rd_valid, 0);
    chk("peek_oob_stk", bus4.stack, 0);

    // SWAP / PEEK
    issue(OP_CLEAR, 32'h0, 2'd0);
    issue(OP_PUSH, 32'hA, 2'd0);
    issue(OP_PUSH, 32'hB, 2'd0);
    issue(OP_SWAP, 32'hC, 2'd0);
    chk("swap_stack", bus4.stack, 32'hB);
    chk("swap_rdv",   bus4.rd_valid, 1);
    chk("swap_esp",   bus4.esp, 2);
    issue(OP_PEEK, 32'h0, 2'd0);
    chk("peek0_stack", bus4.stack, 32'hC);
    issue(OP_PEEK, 32'h0, 2'd1);
    chk("peek1_stack", bus4.stack, 32'hA);
    chk("peek1_rdv",   bus4.rd_valid, 1);
    chk("peek1_udf",   bus4.underflow, 0);
    issue(OP_PEEK, 32'h0, 2'd2);
    chk("peek2_udf",   bus4.underflow, 1);
    chk("peek2_rdv",   bus4.rd_valid, 0);
    chk("peek2_stack", bus4.stack, 32'hA);
    chk("peek2_esp",   bus4.esp, 2);
    issue(OP_NOP, 32'hDEAD, 2'd3);
    chk("nop_esp",   bus4.esp, 2);
    chk("nop_rdv",   bus4.rd_valid, 0);
    chk("nop_stack", bus4.stack, 32'hA);
    issue(3'b110, 32'hBEEF, 2'd1);
    chk("op6_esp", bus4.esp, 2);
    chk("op6_rdv", bus4.rd_valid, 0);
    issue(OP_POP, 32'h0, 2'd0);
    chk("pop2_stack", bus4.stack, 32'hC);
    chk("pop2_esp",   bus4.esp, 3);
    issue(OP_POP, 32'h0, 2'd0);
    chk("pop3_stack", bus4.stack, 32'hA);
    chk("pop3_empty", bus4.empty, 1);

    // reset mid-operation
    issue(OP_PUSH, 32'h5, 2'd0);
    chk("pre_rst_esp", bus4.esp, 3);
    reset = 1'b0;
    #2;
    chk("mid_rst_esp",   bus4.esp, 4);
    chk("mid_rst_stack", bus4.stack, 0);
    chk("mid_rst_ready", bus4.op_ready, 0);
    chk("mid_rst_state", st4, ST_CLEAR);
    #1;
    reset = 1'b1;
    repeat (4) tick();
    chk("mid_rst_ready_back", bus4.op_ready, 1);

    // reset during the clear sweep at index 2
    issue(OP_CLEAR, 32'h0, 2'd0);
    tick();
    tick();
    chk("clr_mid_idx", idx4, 2);
    reset = 1'b0;
    #2;
    chk("clr_rst_idx",   idx4, 0);
    chk("clr_rst_esp",   bus4.esp, 4);
    chk("clr_rst_ready", bus4.op_ready, 0);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("restart_ready", bus4.op_ready, (i == 4) ? 1 : 0);
      if (i < 4) chk("restart_idx", idx4, i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of one stack entry.
REQ-002 SHALL have parameter DEPTH, default 32: number of entries; power of two, >= 2; AW = log2(DEPTH).
REQ-003 SHALL have port clock, input, 1: single rising-edge clock; one clock; all state on this clock.
REQ-004 SHALL have port reset, input, 1: reset is asynchronous and active-low.
REQ-005 SHALL have port op_valid, input, 1: command present.
REQ-006 SHALL have port op_ready, output, 1: command accepted when op_valid && op_ready at a clock edge.
REQ-007 SHALL have port op, input, 3: 000 NOP, 001 PUSH, 010 POP, 011 SWAP, 100 PEEK, 101 CLEAR; 110/111 behave as NOP.
REQ-008 SHALL have port write_data, input, DATA_W: PUSH/SWAP operand.
REQ-009 SHALL have port offset, input, AW: PEEK depth below top (0 = top).
REQ-010 SHALL have port stack, output, DATA_W: registered read result.
REQ-011 SHALL have port rd_valid, output, 1: one-cycle pulse, stack updated this cycle.
REQ-012 SHALL have port esp, output, AW+1: stack pointer, DEPTH = empty, 0 = full.
REQ-013 SHALL have ports empty, full, overflow, underflow, outputs, 1 each.

Function
REQ-014 SHALL grow downward: PUSH writes mem[esp-1], esp <= esp-1.
REQ-015 SHALL on POP: stack <= mem[esp], esp <= esp+1, rd_valid next cycle (latency 1).
REQ-016 SHALL on SWAP: stack <= old mem[esp], mem[esp] <= write_data, esp unchanged, rd_valid next cycle.
REQ-017 SHALL on PEEK: stack <= mem[esp+offset], esp unchanged, rd_valid next cycle.
REQ-018 SHALL drive empty = (esp == DEPTH), full = (esp == 0), combinational from esp.
REQ-019 SHALL on PUSH when full: no write, esp unchanged, overflow set.
REQ-020 SHALL on POP/SWAP when empty, or PEEK with esp+offset >= DEPTH: no state change except underflow set; rd_valid stays low; stack holds.
REQ-021 SHALL keep overflow/underflow sticky until CLEAR completes or reset.
REQ-022 SHALL implement FSM IDLE/CLEAR: IDLE -> CLEAR on accepted CLEAR op or reset release; CLEAR writes zero to mem[0..DEPTH-1], one entry per cycle ascending; CLEAR -> IDLE after entry DEPTH-1.
REQ-023 SHALL hold op_ready = 1 in IDLE and 0 in CLEAR (DEPTH cycles); commands are not accepted in CLEAR.
REQ-024 SHALL on CLEAR entry set esp <= DEPTH, stack <= 0, overflow <= 0, underflow <= 0.
REQ-025 SHALL ignore write_data/offset except on accepted ops that use them; NOP changes nothing.

Reset
REQ-026 SHALL on reset low, immediately: esp = DEPTH, stack = 0, rd_valid = 0, overflow = 0, underflow = 0, op_ready = 0, FSM = CLEAR, clear index = 0.
REQ-027 SHALL after reset release run the full CLEAR sequence, op_ready rising on cycle DEPTH+1.
REQ-028 SHALL on reset asserted mid-CLEAR or mid-operation abandon it and restart per REQ-026.

Structure
REQ-029 SHALL place op encodings and FSM state type in shared package stack_pkg.
REQ-030 SHALL instantiate sub-module stack_ram (DEPTH x DATA_W, 1 write port, 1 read port, registered read) holding the storage; no reset on the array.

Verification
REQ-031 SHALL test reset then wait: op_ready low 32 cycles, then high; esp=32, empty=1.
REQ-032 SHALL test DEPTH=4, PUSH 0x11,0x22,0x33,0x44 -> esp 3,2,1,0, full=1; PUSH 0x55 -> overflow=1, esp=0; POP -> stack=0x44 one cycle after, esp=1.
REQ-033 SHALL test POP on empty -> underflow=1, rd_valid never pulses, esp=DEPTH.
REQ-034 SHALL test after pushes 0xA,0xB: SWAP 0xC -> stack=0xB; PEEK offset 1 -> stack=0xA; PEEK offset 2 -> underflow=1.
REQ-035 SHALL test CLEAR with flags set -> flags 0, op_ready low DEPTH cycles, subsequent PEEK after one PUSH offset 1 -> underflow, memory reads 0 via push/swap.
REQ-036 SHALL test reset pulsed mid-CLEAR at index 2 -> esp=DEPTH, CLEAR restarts from index 0.
